alu_control_muldiv: RTL
=======================

# alu_control_muldiv

Parametrised successor to the single-cycle ALU control decoder. It keeps the aluop/func to alu_select decode and adds a multi-cycle multiply/divide unit with HI/LO registers, MFHI/MFLO reads and a stall handshake to the core. It sits in the decode/execute stage beside the main ALU; the main ALU datapath is unchanged.

## Interface
- WIDTH, 32: operand and HI/LO width; any even value ≥ 8.
- CNT_W, $clog2(WIDTH)+1: iteration counter width (derived; do not override).

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- aluop  in  2  main-control ALU op class (00 mem, 01 branch, 10 R-type, 11 reserved)
- func  in  6  R-type function field
- issue  in  1  instruction in decode is valid this cycle
- rs_val  in  WIDTH  first operand (dividend / multiplicand)
- rt_val  in  WIDTH  second operand (divisor / multiplier)
- alu_select  out  4  {AINV, BINV, OP[1:0]}; OP 00 AND, 01 OR, 10 ADD, 11 SLT
- hilo_sel  out  1  result mux: take hilo_data instead of the ALU output
- hilo_data  out  WIDTH  HI or LO value for MFHI/MFLO
- busy  out  1  multiply/divide in progress
- done  out  1  one-cycle pulse when HI/LO are updated
- stall  out  1  hold the instruction in decode; the core re-presents it next cycle

## Operation
- Decode is combinational. aluop 00 → 0010; aluop 01 → 0110; aluop 11 → 0000. aluop 10 uses func:
  - 100000 → 0010; 100010 → 0110; 100100 → 0000; 100101 → 0001.
  - 100110 → 1100 (NOR); 100111 → 1101 (NAND); 101010 → 0111.
  - Any other func → 0000. No latches.
- Mul/div funcs: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011. They drive alu_select 0000 and start the unit when issue=1, aluop=10 and stall=0.
- MFHI 010000 and MFLO 010010 set hilo_sel=1. hilo_data = HI or LO, combinationally.
- stall=1 when issue=1, aluop=10, busy=1, and func is MFHI, MFLO or any mul/div. Otherwise stall=0.
- FSM states:
  - IDLE → RUN on an accepted start. Operands are captured; signed ops record operand signs and operate on magnitudes.
  - RUN: one radix-2 step per cycle. Multiply is shift-add; divide is restoring. Runs WIDTH cycles → FIX.
  - FIX: negate the product, quotient or remainder as required. Write {HI, LO}, pulse done, return to IDLE.
- Multiply: {HI, LO} = full 2·WIDTH-bit product.
- Divide: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- Divide by zero (either sign mode): skip RUN and go IDLE → FIX. Result is LO = all ones, HI = dividend.
- Signed overflow, most-negative / −1: LO = most-negative, HI = 0. This is two's-complement wrap, not an error.
- All magnitude arithmetic is on WIDTH+1 bits, so the most-negative operand is handled without overflow.

## Timing
- Reset values: HI=0, LO=0, busy=0, done=0, FSM in IDLE. stall and hilo_sel follow their combinational inputs.
- Start accepted at edge E0. busy=1 from E0 through the FIX edge.
- Normal op: done pulses in the cycle after edge E0+WIDTH+1; HI/LO are visible the same cycle. Latency is WIDTH+2 cycles from issue to a readable result.
- Divide by zero: done after edge E0+1.
- An MFHI/MFLO issued in the done cycle is not stalled and reads the new value.
- A new mul/div is accepted in the cycle busy first reads 0. There is no back-to-back overlap.
- Reset mid-operation aborts the op with no HI/LO write and no done pulse.
- Ops other than mul/div/MF* are never stalled while busy.

## Structure
- Package alu_ctrl_pkg holds:
  - function-code constants;
  - alu_select codes (SEL_AND, SEL_OR, SEL_ADD, SEL_SUB, SEL_SLT, SEL_NOR, SEL_NAND);
  - aluop constants;
  - FSM state enum {IDLE, RUN, FIX}.
- Sub-module muldiv_iter(WIDTH) owns the FSM, counter, operand/partial registers and sign fix-up.
- The top level holds the decode, the HI/LO registers and the stall logic.

## Test plan
- Decode sweep: every listed func with aluop=10, plus aluop 00/01/11 → the codes above; unknown func 111111 → 0000.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=FFFFFFFE, LO=00000001. done exactly 34 cycles after issue.
- MULT −3 × 7 → HI=FFFFFFFF, LO=FFFFFFEB. DIV −7 / 2 → LO=FFFFFFFD, HI=FFFFFFFF.
- DIVU 5 / 0 → LO=FFFFFFFF, HI=00000005, done 2 cycles after issue. DIV 80000000 / FFFFFFFF → LO=80000000, HI=0.
- MFLO issued 5 cycles after MULT 6 × 7 → stall held until the done cycle, then hilo_sel=1 and hilo_data=0000002A. An ADD issued while busy → no stall, alu_select=0010.
- Reset pulse at cycle 10 of a DIVU → busy=0, HI=LO=0 immediately, no done. A following MULTU 2 × 3 → LO=6.

Source files
------------

// File: rtl/alu_control_muldiv_pkg.sv
// Shared constants for the ALU control decoder and the iterative mul/div unit.
package alu_ctrl_pkg;

  // Main-control ALU op classes
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_RSVD   = 2'b11;

  // R-type function codes
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100110;
  localparam logic [5:0] F_NAND  = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  // alu_select = {AINV, BINV, OP[1:0]}
  localparam logic [3:0] SEL_AND  = 4'b0000;
  localparam logic [3:0] SEL_OR   = 4'b0001;
  localparam logic [3:0] SEL_ADD  = 4'b0010;
  localparam logic [3:0] SEL_SUB  = 4'b0110;
  localparam logic [3:0] SEL_SLT  = 4'b0111;
  localparam logic [3:0] SEL_NOR  = 4'b1100;
  localparam logic [3:0] SEL_NAND = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  function automatic logic is_muldiv(input logic [5:0] func);
    return (func == F_MULT) || (func == F_MULTU) || (func == F_DIV) || (func == F_DIVU);
  endfunction

  // Combinational aluop/func decode; unknown codes fall back to AND.
  function automatic logic [3:0] alu_decode(input logic [1:0] aluop, input logic [5:0] func);
    logic [3:0] sel;
    sel = SEL_AND;
    case (aluop)
      ALUOP_MEM:    sel = SEL_ADD;
      ALUOP_BRANCH: sel = SEL_SUB;
      ALUOP_RTYPE: begin
        case (func)
          F_ADD:   sel = SEL_ADD;
          F_SUB:   sel = SEL_SUB;
          F_AND:   sel = SEL_AND;
          F_OR:    sel = SEL_OR;
          F_NOR:   sel = SEL_NOR;
          F_NAND:  sel = SEL_NAND;
          F_SLT:   sel = SEL_SLT;
          default: sel = SEL_AND;
        endcase
      end
      default:      sel = SEL_AND;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_control_muldiv_muldiv_iter.sv
// Radix-2 iterative multiply (shift-add) / divide (restoring) engine.
// Works on operand magnitudes and applies the sign fix-up in the FIX state.
module muldiv_iter
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_signed,
  input  logic             op_div,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output md_state_t        state,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  md_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   acc_q;   // partial product high half / remainder
  logic [WIDTH-1:0] lo_q;    // multiplier being consumed / quotient being built
  logic [WIDTH-1:0] b_q;     // multiplicand / divisor magnitude
  logic             div_q;
  logic             dz_q;
  logic             neg_lo_q;
  logic             neg_hi_q;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] prod_fix;

  assign state = state_q;

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    mag_a = rs_val;
    mag_b = rt_val;
    if (op_signed && rs_val[WIDTH-1]) mag_a = -rs_val;
    if (op_signed && rt_val[WIDTH-1]) mag_b = -rt_val;
  end

  // One iteration step for each operation, plus the final signed results.
  always_comb begin
    mul_sum   = acc_q + {1'b0, (lo_q[0] ? b_q : '0)};
    div_shift = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    product   = {acc_q[WIDTH-1:0], lo_q};
    prod_fix  = neg_lo_q ? -product : product;
    if (dz_q) begin
      res_hi = acc_q[WIDTH-1:0];
      res_lo = lo_q;
    end else if (div_q) begin
      res_hi = neg_hi_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      res_lo = neg_lo_q ? -lo_q : lo_q;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  // FSM and datapath registers: IDLE -> RUN (WIDTH steps) -> FIX -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      div_q    <= 1'b0;
      dz_q     <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            div_q    <= op_div;
            cnt_q    <= '0;
            neg_lo_q <= op_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            neg_hi_q <= op_signed && (op_div ? rs_val[WIDTH-1] : (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]));
            if (op_div && (rt_val == '0)) begin
              // Divide by zero bypasses iteration with a fixed result.
              dz_q    <= 1'b1;
              acc_q   <= {1'b0, rs_val};
              lo_q    <= '1;
              state_q <= FIX;
            end else begin
              dz_q    <= 1'b0;
              acc_q   <= '0;
              lo_q    <= op_div ? mag_a : mag_b;
              b_q     <= op_div ? mag_b : mag_a;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (div_q) begin
            if (div_shift >= {1'b0, b_q}) begin
              acc_q <= div_diff;
              lo_q  <= {lo_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_q <= div_shift;
              lo_q  <= {lo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_q <= {1'b0, mul_sum[WIDTH:1]};
            lo_q  <= {mul_sum[0], lo_q[WIDTH-1:1]};
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIX;
        end
        FIX:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_control_muldiv.sv
// ALU control decoder with an attached multi-cycle multiply/divide unit,
// HI/LO registers, MFHI/MFLO read path and decode-stage stall.
//
// Handshake: the core presents an instruction with issue=1. If stall=1 in
// that cycle the instruction is not consumed and the core re-presents it the
// next cycle; with stall=0 it is consumed at the rising edge. A mul/div start
// is accepted exactly when issue=1, aluop=R-type, func is mul/div and stall=0.
module alu_control_muldiv
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       aluop,
  input  logic [5:0]       func,
  input  logic             issue,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [3:0]       alu_select,
  output logic             hilo_sel,
  output logic [WIDTH-1:0] hilo_data,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  md_state_t        md_state;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             rtype;
  logic             is_mf;
  logic             is_md;
  logic             start;
  logic             fix;

  // Decode, result-mux select and stall generation.
  always_comb begin
    rtype      = (aluop == ALUOP_RTYPE);
    is_mf      = (func == F_MFHI) || (func == F_MFLO);
    is_md      = is_muldiv(func);
    alu_select = alu_decode(aluop, func);
    busy       = (md_state != IDLE);
    fix        = (md_state == FIX);
    hilo_sel   = rtype && is_mf;
    hilo_data  = (func == F_MFHI) ? hi_q : lo_q;
    stall      = issue && rtype && busy && (is_mf || is_md);
    start      = issue && rtype && is_md && !stall;
  end

  assign done = done_q;

  muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk       (clk),
    .rst       (reset),
    .start     (start),
    .op_signed ((func == F_MULT) || (func == F_DIV)),
    .op_div    ((func == F_DIV) || (func == F_DIVU)),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .state     (md_state),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  // HI/LO are written in the FIX state; done follows one cycle later with the new values visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= fix;
      if (fix) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

endmodule
